dmul_arb_ctrl: RTL and testbench

DMUL_ARB_CTRL -- requirements
Module: dmul_arb_ctrl

---
 rtl/dmul_arb_if.sv | 36 +++
 rtl/dmul_arb_ctrl.sv | 106 ++++++++++
 tb/tb_dmul_arb_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmul_arb_if.sv
// Bus between two requesters, the shared stochastic multiplier and the result
// consumer. The arbiter controller is the slave; the environment is the master.
interface dmul_arb_if #(parameter int DATAWD = 8);
  logic              req0_valid;
  logic              req1_valid;
  logic [DATAWD-1:0] req0_a;
  logic [DATAWD-1:0] req0_b;
  logic [DATAWD-1:0] req1_a;
  logic [DATAWD-1:0] req1_b;
  logic              req0_ready;
  logic              req1_ready;
  logic [DATAWD-1:0] mul_iA;
  logic [DATAWD-1:0] mul_iB;
  logic              mul_loadA;
  logic              mul_loadB;
  logic [2*DATAWD-1:0] mul_oC;
  logic              res_valid;
  logic              res_ready;
  logic [2*DATAWD-1:0] res_data;
  logic              res_id;
  logic              busy;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  mul_oC, res_ready,
    output req0_ready, req1_ready, mul_iA, mul_iB, mul_loadA, mul_loadB,
    output res_valid, res_data, res_id, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output mul_oC, res_ready,
    input  req0_ready, req1_ready, mul_iA, mul_iB, mul_loadA, mul_loadB,
    input  res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/dmul_arb_ctrl.sv
// Two-requester round-robin front end for a shared stochastic multiplier:
// accepts one operand pair, runs the multiplier for RUN_LEN cycles, returns the count.
//
// state   | meaning
// IDLE    | waiting for a request; ready asserted for the granted requester
// LOAD    | one-cycle load strobe, clears the multiplier count
// RUN     | multiplier accumulating for RUN_LEN cycles
// CAPTURE | register the multiplier count
// RESULT  | result held until res_ready
module dmul_arb_ctrl #(
  parameter int DATAWD  = 8,
  parameter int RUN_LEN = 255
) (
  input logic      clk,
  input logic      rst,
  dmul_arb_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, RESULT} state_t;

  localparam logic [15:0] RUN_LAST = 16'(RUN_LEN - 1);

  state_t              state;
  state_t              stateNext;
  logic                prioPtr;
  logic [15:0]         runCnt;
  logic [DATAWD-1:0]   opA;
  logic [DATAWD-1:0]   opB;
  logic [2*DATAWD-1:0] resData;
  logic                resId;
  logic                grant0;
  logic                grant1;
  logic                accept;

  // Pointer only matters on a tie; a lone valid always wins.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~prioPtr);
  assign grant1 = bus.req1_valid & (~bus.req0_valid |  prioPtr);
  assign accept = (state == IDLE) & (grant0 | grant1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      prioPtr <= 1'b0;
      runCnt  <= '0;
      opA     <= '0;
      opB     <= '0;
      resData <= '0;
      resId   <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (accept) begin
            opA   <= grant1 ? bus.req1_a : bus.req0_a;
            opB   <= grant1 ? bus.req1_b : bus.req0_b;
            resId <= grant1;
          end
        end
        LOAD:    runCnt  <= '0;
        RUN:     runCnt  <= runCnt + 16'd1;
        CAPTURE: resData <= bus.mul_oC;
        RESULT: begin
          if (bus.res_ready) prioPtr <= ~resId;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext      = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.mul_loadA  = 1'b0;
    bus.mul_loadB  = 1'b0;
    bus.res_valid  = 1'b0;
    case (state)
      IDLE: begin
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        if (accept) stateNext = LOAD;
      end
      LOAD: begin
        bus.mul_loadA = 1'b1;
        bus.mul_loadB = 1'b1;
        stateNext     = RUN;
      end
      RUN: begin
        if (runCnt == RUN_LAST) stateNext = CAPTURE;
      end
      CAPTURE: stateNext = RESULT;
      RESULT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.mul_iA   = opA;
  assign bus.mul_iB   = opB;
  assign bus.res_data = resData;
  assign bus.res_id   = resId;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_dmul_arb_ctrl.sv
// Randomized bench for dmul_arb_ctrl: a stand-in multiplier returns the exact
// product only after a full run, and a round-robin model predicts grants and results.
module tb_dmul_arb_ctrl;

  localparam int RL0 = 255;
  localparam int RL1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  logic modelPtr = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmul_arb_if #(.DATAWD(8)) bus0 ();
  dmul_arb_if #(.DATAWD(8)) bus1 ();

  dmul_arb_ctrl #(.DATAWD(8), .RUN_LEN(RL0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dmul_arb_ctrl #(.DATAWD(8), .RUN_LEN(RL1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Stand-in multipliers: count elapsed cycles since load; only a full run yields a*b.
  logic [15:0] cnt0 = '0, cnt1 = '0;
  logic [7:0]  mA0 = '0, mB0 = '0, mA1 = '0, mB1 = '0;
  always @(posedge clk) begin
    if (bus0.mul_loadA) begin cnt0 <= '0; mA0 <= bus0.mul_iA; end else cnt0 <= cnt0 + 16'd1;
    if (bus0.mul_loadB) mB0 <= bus0.mul_iB;
    if (bus1.mul_loadA) begin cnt1 <= '0; mA1 <= bus1.mul_iA; end else cnt1 <= cnt1 + 16'd1;
    if (bus1.mul_loadB) mB1 <= bus1.mul_iB;
  end
  assign bus0.mul_oC = (cnt0 == 16'(RL0)) ? {8'd0, mA0} * {8'd0, mB0} : (16'hA5A5 ^ cnt0);
  assign bus1.mul_oC = (cnt1 == 16'(RL1)) ? {8'd0, mA1} * {8'd0, mB1} : (16'hA5A5 ^ cnt1);

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.req0_valid = 0; bus0.req1_valid = 0; bus0.res_ready = 0;
    bus0.req0_a = 0; bus0.req0_b = 0; bus0.req1_a = 0; bus0.req1_b = 0;
    bus1.req0_valid = 0; bus1.req1_valid = 0; bus1.res_ready = 0;
    bus1.req0_a = 0; bus1.req0_b = 0; bus1.req1_a = 0; bus1.req1_b = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    modelPtr = 1'b0;
  endtask

  task automatic wait_res0(input int limit, output bit timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < limit; i++) begin
      if (bus0.res_valid) begin timedOut = 1'b0; break; end
      tick();
    end
  endtask

  task automatic finish_res0();
    bus0.res_ready = 1'b1;
    tick();
    bus0.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus0.busy !== 1'b0) $display("FAIL reset_busy: got %0d expected 0", bus0.busy); else passed++;
    checks++; if (bus0.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %0d expected 0", bus0.res_valid); else passed++;
    checks++; if (bus0.res_data !== 16'd0) $display("FAIL reset_res_data: got %0d expected 0", bus0.res_data); else passed++;
    checks++; if (bus0.res_id !== 1'b0) $display("FAIL reset_res_id: got %0d expected 0", bus0.res_id); else passed++;
    checks++; if ({bus0.mul_loadA, bus0.mul_loadB} !== 2'b00) $display("FAIL reset_loads: got %0d expected 0", {bus0.mul_loadA, bus0.mul_loadB}); else passed++;
    checks++; if ({bus0.mul_iA, bus0.mul_iB} !== 16'd0) $display("FAIL reset_operands: got %0d expected 0", {bus0.mul_iA, bus0.mul_iB}); else passed++;
  endtask

  task automatic test_req0_only();
    int t; bit to;
    do_reset();
    bus0.req0_valid = 1; bus0.req0_a = 8'd0; bus0.req0_b = 8'd200;
    #1;
    checks++; if (bus0.req0_ready !== 1'b1) $display("FAIL r0_ready: got %0d expected 1", bus0.req0_ready); else passed++;
    t = cyc;
    tick();
    checks++; if (bus0.req0_ready !== 1'b0) $display("FAIL r0_ready_one_cycle: got %0d expected 0", bus0.req0_ready); else passed++;
    checks++; if (bus0.mul_loadA !== 1'b1) $display("FAIL r0_loadA: got %0d expected 1", bus0.mul_loadA); else passed++;
    checks++; if ({bus0.mul_iA, bus0.mul_iB} !== {8'd0, 8'd200}) $display("FAIL r0_operands: got %0d expected %0d", {bus0.mul_iA, bus0.mul_iB}, {8'd0, 8'd200}); else passed++;
    bus0.req0_valid = 0;
    wait_res0(400, to);
    checks++; if (to) $display("FAIL r0_timeout: got no res_valid expected one"); else passed++;
    checks++; if (cyc - t !== RL0 + 3) $display("FAIL r0_latency: got %0d expected %0d", cyc - t, RL0 + 3); else passed++;
    checks++; if (bus0.res_data !== 16'd0) $display("FAIL r0_data: got %0d expected 0", bus0.res_data); else passed++;
    checks++; if (bus0.res_id !== 1'b0) $display("FAIL r0_id: got %0d expected 0", bus0.res_id); else passed++;
    finish_res0();
  endtask

  task automatic test_both_valid();
    logic [7:0] a0, b0, a1, b1; bit to; int t;
    do_reset();
    a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    bus0.req0_valid = 1; bus0.req0_a = a0; bus0.req0_b = b0;
    bus0.req1_valid = 1; bus0.req1_a = a1; bus0.req1_b = b1;
    #1;
    checks++; if ({bus0.req1_ready, bus0.req0_ready} !== 2'b01) $display("FAIL both_first_grant: got %0d expected 1", {bus0.req1_ready, bus0.req0_ready}); else passed++;
    tick();
    bus0.req0_valid = 0;
    wait_res0(400, to);
    checks++; if (to) $display("FAIL both_timeout0: got no res_valid expected one"); else passed++;
    checks++; if (bus0.res_id !== 1'b0) $display("FAIL both_id0: got %0d expected 0", bus0.res_id); else passed++;
    checks++; if (bus0.res_data !== {8'd0, a0} * {8'd0, b0}) $display("FAIL both_data0: got %0d expected %0d", bus0.res_data, {8'd0, a0} * {8'd0, b0}); else passed++;
    checks++; if (bus0.req1_ready !== 1'b0) $display("FAIL both_no_accept_in_result: got %0d expected 0", bus0.req1_ready); else passed++;
    finish_res0();
    modelPtr = 1'b1;
    checks++; if (bus0.req1_ready !== 1'b1) $display("FAIL both_req1_next_cycle: got %0d expected 1", bus0.req1_ready); else passed++;
    t = cyc;
    tick();
    bus0.req1_valid = 0;
    wait_res0(400, to);
    checks++; if (to) $display("FAIL both_timeout1: got no res_valid expected one"); else passed++;
    checks++; if (cyc - t !== RL0 + 3) $display("FAIL both_latency1: got %0d expected %0d", cyc - t, RL0 + 3); else passed++;
    checks++; if (bus0.res_id !== 1'b1) $display("FAIL both_id1: got %0d expected 1", bus0.res_id); else passed++;
    checks++; if (bus0.res_data !== {8'd0, a1} * {8'd0, b1}) $display("FAIL both_data1: got %0d expected %0d", bus0.res_data, {8'd0, a1} * {8'd0, b1}); else passed++;
    finish_res0();
  endtask

  task automatic test_alternate();
    logic [7:0] a, b; logic [15:0] exp; bit to; bit seen;
    do_reset();
    bus0.req0_valid = 1; bus0.req0_a = 8'($urandom); bus0.req0_b = 8'($urandom);
    bus0.req1_valid = 1; bus0.req1_a = 8'($urandom); bus0.req1_b = 8'($urandom);
    #1;
    for (int op = 0; op < 4; op++) begin
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (bus0.req0_ready | bus0.req1_ready) begin seen = 1'b1; break; end
        tick();
      end
      checks++; if (!seen) $display("FAIL alt_grant_timeout: got no ready expected one"); else passed++;
      checks++; if ({bus0.req1_ready, bus0.req0_ready} !== (modelPtr ? 2'b10 : 2'b01)) $display("FAIL alt_grant: got %0d expected %0d", {bus0.req1_ready, bus0.req0_ready}, modelPtr ? 2 : 1); else passed++;
      a = modelPtr ? bus0.req1_a : bus0.req0_a;
      b = modelPtr ? bus0.req1_b : bus0.req0_b;
      exp = {8'd0, a} * {8'd0, b};
      tick();
      // New operands for the winner while busy; they must not disturb this run.
      if (modelPtr) begin bus0.req1_a = 8'($urandom); bus0.req1_b = 8'($urandom); end
      else          begin bus0.req0_a = 8'($urandom); bus0.req0_b = 8'($urandom); end
      wait_res0(400, to);
      checks++; if (to) $display("FAIL alt_timeout: got no res_valid expected one"); else passed++;
      checks++; if (bus0.res_id !== modelPtr) $display("FAIL alt_id: got %0d expected %0d", bus0.res_id, modelPtr); else passed++;
      checks++; if (bus0.res_data !== exp) $display("FAIL alt_data: got %0d expected %0d", bus0.res_data, exp); else passed++;
      finish_res0();
      modelPtr = ~modelPtr;
    end
    bus0.req0_valid = 0; bus0.req1_valid = 0;
  endtask

  task automatic test_hold();
    logic [7:0] a, b; logic [15:0] exp; bit to;
    do_reset();
    a = 8'($urandom); b = 8'($urandom); exp = {8'd0, a} * {8'd0, b};
    bus0.req1_valid = 1; bus0.req1_a = a; bus0.req1_b = b;
    tick();
    bus0.req1_valid = 0;
    wait_res0(400, to);
    checks++; if (to) $display("FAIL hold_timeout: got no res_valid expected one"); else passed++;
    bus0.req0_valid = 1; bus0.req1_valid = 1;
    #1;
    for (int j = 0; j < 10; j++) begin
      checks++; if (bus0.res_valid !== 1'b1) $display("FAIL hold_valid: got %0d expected 1", bus0.res_valid); else passed++;
      checks++; if (bus0.res_data !== exp) $display("FAIL hold_data: got %0d expected %0d", bus0.res_data, exp); else passed++;
      checks++; if (bus0.res_id !== 1'b1) $display("FAIL hold_id: got %0d expected 1", bus0.res_id); else passed++;
      checks++; if ({bus0.req0_ready, bus0.req1_ready} !== 2'b00) $display("FAIL hold_readies: got %0d expected 0", {bus0.req0_ready, bus0.req1_ready}); else passed++;
      checks++; if (bus0.busy !== 1'b1) $display("FAIL hold_busy: got %0d expected 1", bus0.busy); else passed++;
      tick();
    end
    bus0.req0_valid = 0; bus0.req1_valid = 0;
    finish_res0();
    checks++; if ({bus0.busy, bus0.res_valid} !== 2'b00) $display("FAIL hold_release: got %0d expected 0", {bus0.busy, bus0.res_valid}); else passed++;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] a, b; bit to, sawValid; int t;
    do_reset();
    bus0.req0_valid = 1; bus0.req0_a = 8'($urandom); bus0.req0_b = 8'($urandom);
    t = cyc;
    tick();
    bus0.req0_valid = 0;
    while (cyc < t + 101) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus0.busy !== 1'b0) $display("FAIL midrst_busy: got %0d expected 0", bus0.busy); else passed++;
    checks++; if (bus0.res_valid !== 1'b0) $display("FAIL midrst_res_valid: got %0d expected 0", bus0.res_valid); else passed++;
    sawValid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus0.res_valid) sawValid = 1'b1;
      tick();
    end
    checks++; if (sawValid) $display("FAIL midrst_stray_result: got 1 expected 0"); else passed++;
    modelPtr = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    bus0.req1_valid = 1; bus0.req1_a = a; bus0.req1_b = b;
    #1;
    checks++; if (bus0.req1_ready !== 1'b1) $display("FAIL midrst_new_ready: got %0d expected 1", bus0.req1_ready); else passed++;
    t = cyc;
    tick();
    bus0.req1_valid = 0;
    wait_res0(400, to);
    checks++; if (to) $display("FAIL midrst_timeout: got no res_valid expected one"); else passed++;
    checks++; if (cyc - t !== RL0 + 3) $display("FAIL midrst_latency: got %0d expected %0d", cyc - t, RL0 + 3); else passed++;
    checks++; if (bus0.res_data !== {8'd0, a} * {8'd0, b}) $display("FAIL midrst_data: got %0d expected %0d", bus0.res_data, {8'd0, a} * {8'd0, b}); else passed++;
    checks++; if (bus0.res_id !== 1'b1) $display("FAIL midrst_id: got %0d expected 1", bus0.res_id); else passed++;
    finish_res0();
  endtask

  task automatic test_run_len1();
    int t, loadsA, loadsB, firstValid;
    do_reset();
    bus1.req0_valid = 1; bus1.req0_a = 8'd255; bus1.req0_b = 8'd255;
    #1;
    checks++; if (bus1.req0_ready !== 1'b1) $display("FAIL rl1_ready: got %0d expected 1", bus1.req0_ready); else passed++;
    t = cyc; loadsA = 0; loadsB = 0; firstValid = -1;
    tick();
    bus1.req0_valid = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus1.mul_loadA) loadsA++;
      if (bus1.mul_loadB) loadsB++;
      if (bus1.res_valid && firstValid < 0) firstValid = cyc - t;
      tick();
    end
    checks++; if (loadsA !== 1) $display("FAIL rl1_loadA_cycles: got %0d expected 1", loadsA); else passed++;
    checks++; if (loadsB !== 1) $display("FAIL rl1_loadB_cycles: got %0d expected 1", loadsB); else passed++;
    checks++; if (firstValid !== RL1 + 3) $display("FAIL rl1_latency: got %0d expected %0d", firstValid, RL1 + 3); else passed++;
    checks++; if (bus1.res_data !== 16'd65025) $display("FAIL rl1_data: got %0d expected 65025", bus1.res_data); else passed++;
    checks++; if (bus1.res_id !== 1'b0) $display("FAIL rl1_id: got %0d expected 0", bus1.res_id); else passed++;
    bus1.res_ready = 1'b1;
    tick();
    bus1.res_ready = 1'b0;
    checks++; if (bus1.busy !== 1'b0) $display("FAIL rl1_release: got %0d expected 0", bus1.busy); else passed++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_req0_only();
    test_both_valid();
    test_alternate();
    test_hold();
    test_reset_mid_run();
    test_run_len1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
